// File: rtl/dma_copy_pkg.sv
// Shared definitions for the dma_copy block: FSM states, register map
// offsets and status word layout.
package dma_copy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } dma_state_e;

    // Slave register offsets (word addresses on the 4-bit slave bus)
    localparam logic [3:0] REG_CTRL        = 4'd0;
    localparam logic [3:0] REG_DEST        = 4'd1;
    localparam logic [3:0] REG_SRC         = 4'd2;
    localparam logic [3:0] REG_NUM         = 4'd3;
    localparam logic [3:0] REG_SRC_STRIDE  = 4'd4;
    localparam logic [3:0] REG_DEST_STRIDE = 4'd5;
    localparam logic [3:0] REG_IRQ         = 4'd6;

    // Status word layout
    localparam int STAT_BUSY_BIT = 31;
    localparam int STAT_DONE_BIT = 30;
    localparam int STAT_CNT_W    = 30;

    // Interrupt control register bits
    localparam int IRQ_EN_BIT  = 0;
    localparam int IRQ_CLR_BIT = 1;

    function automatic logic [31:0] pack_status(input logic busy,
                                                input logic done,
                                                input logic [STAT_CNT_W-1:0] cnt);
        return {busy, done, cnt};
    endfunction

endpackage

// File: rtl/dma_copy_if.sv
// Bus bundle for dma_copy: the register slave port and the memory master port.
//
// Handshake: both ports use waitrequest-style flow control. A requester
// raises read or write together with address (and writedata) and must hold
// all of them unchanged while waitrequest is high; the transfer completes on
// the rising edge where the request is high and waitrequest is low. Read data
// on the master port returns later, one word per cycle with readdatavalid, in
// request order. On the slave port read data is valid the cycle after the
// read is accepted.
//
// Modport "master" is the DMA engine's view (drives the memory request and
// answers the register bus); modport "slave" is the environment's view.
interface dma_copy_if #(
    parameter int DATA_W = 32
);
    logic              slave_waitrequest;
    logic [3:0]        slave_address;
    logic              slave_read;
    logic [31:0]       slave_readdata;
    logic              slave_write;
    logic [31:0]       slave_writedata;

    logic              master_waitrequest;
    logic [31:0]       master_address;
    logic              master_read;
    logic [DATA_W-1:0] master_readdata;
    logic              master_readdatavalid;
    logic              master_write;
    logic [DATA_W-1:0] master_writedata;

    modport master (
        output slave_waitrequest,
        input  slave_address,
        input  slave_read,
        output slave_readdata,
        input  slave_write,
        input  slave_writedata,
        input  master_waitrequest,
        output master_address,
        output master_read,
        input  master_readdata,
        input  master_readdatavalid,
        output master_write,
        output master_writedata
    );

    modport slave (
        input  slave_waitrequest,
        output slave_address,
        output slave_read,
        input  slave_readdata,
        output slave_write,
        output slave_writedata,
        output master_waitrequest,
        input  master_address,
        input  master_read,
        output master_readdata,
        output master_readdatavalid,
        input  master_write,
        input  master_writedata
    );

endinterface

// File: rtl/dma_fifo.sv
// Read-data buffer for dma_copy: synchronous FIFO with first-word
// fall-through output, full/empty flags and an occupancy count.
module dma_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rd_data = mem[rd_ptr];

    // Storage array write; contents need no reset since pointers gate reads
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-2 depth)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/dma_copy.sv
// dma_copy: register-programmed strided memory-to-memory copy engine.
// Reads words from src with src_stride, buffers them in dma_fifo and writes
// them to dest with dest_stride. Optional interrupt support is compiled in
// with the macro DMA_COPY_IRQ_EN (adds irq output and register 6).
module dma_copy
    import dma_copy_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    dma_copy_if.master  bus,
`ifdef DMA_COPY_IRQ_EN
    output logic        irq,
`endif
    output dma_state_e  dbg_state
);

    localparam int              FC_W       = $clog2(FIFO_DEPTH) + 1;
    localparam int              CNT_W      = $clog2(FIFO_DEPTH) + 2;
    localparam logic [31:0]     WORD_BYTES = 32'(DATA_W / 8);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);

    dma_state_e state_q;
    dma_state_e state_d;

    // Programmed registers (frozen while a copy is running)
    logic [31:0] dest_r;
    logic [31:0] src_r;
    logic [31:0] num_r;
    logic [31:0] src_stride_r;
    logic [31:0] dest_stride_r;
    logic        done_r;
`ifdef DMA_COPY_IRQ_EN
    logic        irq_en_r;
`endif

    // Copy progress
    logic [31:0]      rd_addr;
    logic [31:0]      wr_addr;
    logic [31:0]      rd_issued;
    logic [31:0]      wr_count;
    logic [CNT_W-1:0] outstanding;

    // Master request register (held stable while waitrequest is high)
    logic              mst_read_q;
    logic              mst_write_q;
    logic [31:0]       mst_addr_q;
    logic [DATA_W-1:0] mst_wdata_q;

    logic [31:0] rdata_q;

    // FIFO
    logic              fifo_push;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FC_W-1:0]   fifo_count;

    // Control decode
    logic             busy;
    logic             ctrl_wr;
    logic             start;
    logic             m_free;
    logic             rd_accept;
    logic             wr_accept;
    logic             last_wr;
    logic             reads_left;
    logic             issue_wr;
    logic             issue_rd;
    logic [CNT_W-1:0] in_use;
    logic [31:0]      src_step;
    logic [31:0]      dest_step;

    assign busy    = (state_q != ST_IDLE);
    assign ctrl_wr = bus.slave_write && (bus.slave_address == REG_CTRL);
    // A start request while busy is stalled on the bus until the copy ends
    assign start   = ctrl_wr && !busy;

    assign m_free     = !(mst_read_q || mst_write_q) || !bus.master_waitrequest;
    assign rd_accept  = mst_read_q && !bus.master_waitrequest;
    assign wr_accept  = mst_write_q && !bus.master_waitrequest;
    assign last_wr    = wr_accept && (wr_count == (num_r - 32'd1));
    assign reads_left = (rd_issued != num_r);

    // Space already claimed: reads in flight, words buffered, and a read
    // still waiting in the request register.
    assign in_use = outstanding + CNT_W'(fifo_count) + CNT_W'(mst_read_q);

    // Writes drain the buffer first; reads only when the buffer is empty
    assign issue_wr = busy && m_free && !fifo_empty;
    assign issue_rd = (state_q == ST_RUN) && m_free && fifo_empty && !fifo_full
                      && reads_left && (in_use < DEPTH_C);

    // Only accept read data we are actually waiting for; responses to reads
    // abandoned by a reset arrive with outstanding == 0 and are dropped.
    assign fifo_push = bus.master_readdatavalid && (outstanding != '0);
    assign fifo_pop  = issue_wr;

    assign src_step  = src_stride_r * WORD_BYTES;
    assign dest_step = dest_stride_r * WORD_BYTES;

    assign bus.slave_waitrequest = ctrl_wr && busy;
    assign bus.slave_readdata    = rdata_q;
    assign bus.master_read       = mst_read_q;
    assign bus.master_write      = mst_write_q;
    assign bus.master_address    = mst_addr_q;
    assign bus.master_writedata  = mst_wdata_q;
    assign dbg_state             = state_q;

`ifdef DMA_COPY_IRQ_EN
    assign irq = done_r & irq_en_r;
`endif

    dma_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .wr_data (bus.master_readdata),
        .pop     (fifo_pop),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: run while reads remain, flush until the last write lands
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start && (num_r != '0)) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (last_wr)          state_d = ST_IDLE;
                else if (!reads_left) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (last_wr) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Programmable registers; writes to 1-5 are accepted but ignored while busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dest_r        <= '0;
            src_r         <= '0;
            num_r         <= '0;
            src_stride_r  <= '0;
            dest_stride_r <= '0;
        end else if (bus.slave_write && !busy) begin
            case (bus.slave_address)
                REG_DEST:        dest_r        <= bus.slave_writedata;
                REG_SRC:         src_r         <= bus.slave_writedata;
                REG_NUM:         num_r         <= bus.slave_writedata;
                REG_SRC_STRIDE:  src_stride_r  <= bus.slave_writedata;
                REG_DEST_STRIDE: dest_stride_r <= bus.slave_writedata;
                default: ;
            endcase
        end
    end

`ifdef DMA_COPY_IRQ_EN
    // Interrupt enable, writable at any time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en_r <= 1'b0;
        end else if (bus.slave_write && (bus.slave_address == REG_IRQ)) begin
            irq_en_r <= bus.slave_writedata[IRQ_EN_BIT];
        end
    end
`endif

    // Sticky done: cleared by start, set by the final write (or an empty copy)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_r <= 1'b0;
        end else if (start) begin
            done_r <= (num_r == '0);
        end else if (last_wr) begin
            done_r <= 1'b1;
`ifdef DMA_COPY_IRQ_EN
        end else if (bus.slave_write && (bus.slave_address == REG_IRQ)
                     && bus.slave_writedata[IRQ_CLR_BIT]) begin
            done_r <= 1'b0;
`endif
        end
    end

    // Count reads accepted by memory but not yet returned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else begin
            case ({rd_accept, fifo_push})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Master request issue, address generation and progress counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr     <= '0;
            wr_addr     <= '0;
            rd_issued   <= '0;
            wr_count    <= '0;
            mst_read_q  <= 1'b0;
            mst_write_q <= 1'b0;
            mst_addr_q  <= '0;
            mst_wdata_q <= '0;
        end else begin
            if (start) begin
                rd_addr   <= src_r;
                wr_addr   <= dest_r;
                rd_issued <= '0;
                wr_count  <= '0;
            end
            if (wr_accept) begin
                wr_count <= wr_count + 32'd1;
            end
            if (m_free) begin
                mst_read_q  <= 1'b0;
                mst_write_q <= 1'b0;
                if (issue_wr) begin
                    mst_write_q <= 1'b1;
                    mst_addr_q  <= wr_addr;
                    mst_wdata_q <= fifo_rdata;
                    wr_addr     <= wr_addr + dest_step;
                end else if (issue_rd) begin
                    mst_read_q <= 1'b1;
                    mst_addr_q <= rd_addr;
                    rd_addr    <= rd_addr + src_step;
                    rd_issued  <= rd_issued + 32'd1;
                end
            end
        end
    end

    // Registered slave read data; status never stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (bus.slave_read) begin
            case (bus.slave_address)
                REG_CTRL:        rdata_q <= pack_status(busy, done_r, wr_count[STAT_CNT_W-1:0]);
                REG_DEST:        rdata_q <= dest_r;
                REG_SRC:         rdata_q <= src_r;
                REG_NUM:         rdata_q <= num_r;
                REG_SRC_STRIDE:  rdata_q <= src_stride_r;
                REG_DEST_STRIDE: rdata_q <= dest_stride_r;
`ifdef DMA_COPY_IRQ_EN
                REG_IRQ:         rdata_q <= {31'd0, irq_en_r};
`endif
                default:         rdata_q <= '0;
            endcase
        end
    end

endmodule

// File: doc/dma_copy.md
DMA_COPY -- requirements
Module: dma_copy

Interface
REQ-001 SHALL have parameter DATA_W, default 32, master and slave data width in bits (multiple of 8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, read-data buffer depth in words (power of 2, >=2).
REQ-003 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have slave_waitrequest out 1; slave_address in 4; slave_read in 1; slave_readdata out 32; slave_write in 1; slave_writedata in 32.
REQ-006 SHALL have master_waitrequest in 1; master_address out 32; master_read out 1; master_readdata in DATA_W; master_readdatavalid in 1; master_write out 1; master_writedata out DATA_W.

Function
REQ-007 SHALL decode slave registers: 0 control/status, 1 dest, 2 src, 3 num_words, 4 src_stride, 5 dest_stride (strides in words, 32-bit, unsigned).
REQ-008 SHALL complete writes to offsets 1-5 and all reads in one cycle with slave_waitrequest low; readdata registered, valid the cycle after the accepted read.
REQ-009 SHALL, on write to offset 0 while busy, hold slave_waitrequest high until state IDLE, then start the copy and drop waitrequest.
REQ-010 SHALL return on read of offset 0, without stalling: bit31 busy, bit30 done (sticky), bits[29:0] words written this copy.
REQ-011 SHALL clear done on copy start; set done the cycle the last write is accepted.
REQ-012 SHALL use states IDLE -> RUN on start; RUN -> FLUSH when all reads issued; FLUSH -> IDLE when last write accepted.
REQ-013 SHALL, on start with num_words == 0, go IDLE directly, set done, issue no master transactions.
REQ-014 SHALL issue read n at src + n*src_stride*(DATA_W/8), write n at dest + n*dest_stride*(DATA_W/8); addresses wrap mod 2^32.
REQ-015 SHALL keep up to FIFO_DEPTH reads outstanding; issue a read only if outstanding + FIFO occupancy < FIFO_DEPTH.
REQ-016 SHALL, per cycle with no request held, issue a write if the FIFO is non-empty, else a read if allowed; writes have priority.
REQ-017 SHALL hold address, read/write and writedata stable while master_waitrequest is high; count acceptance only when it is low.
REQ-018 SHALL push master_readdata into the FIFO on master_readdatavalid, in order; the FIFO never overflows by REQ-015.
REQ-019 SHALL ignore register writes to offsets 1-5 while busy (values unchanged; write accepted).

Reset
REQ-020 SHALL on rst_n low asynchronously enter IDLE; clear all registers, counters, FIFO, done; master_read/write low; slave_readdata 0; slave_waitrequest low.
REQ-021 SHALL abandon any in-flight copy on reset mid-operation; readdatavalid returning after reset release SHALL be discarded.

Configuration
REQ-022 SHALL with macro DMA_COPY_IRQ_EN defined add output irq (1 bit) and register 6 bit0 irq_enable; irq = done & irq_enable; writing 1 to register 6 bit1 clears done.
REQ-023 SHALL without DMA_COPY_IRQ_EN have no irq port; offset 6 reads 0 and writes are ignored.

Structure
REQ-024 SHALL place state enum, register offset constants and status bit positions in package dma_copy_pkg.
REQ-025 SHALL implement the buffer as sub-module dma_fifo (synchronous, parameterised width/depth, full/empty/count).

Verification
REQ-026 Bench: src=0x100, dest=0x200, num=4, strides 1, zero-wait memory -> writes 0x200,0x204,0x208,0x20C carry words from 0x100-0x10C; done=1, status=0x40000004.
REQ-027 Bench: src_stride=2, dest_stride=3, num=3 -> reads 0x100,0x108,0x110; writes 0x200,0x20C,0x218.
REQ-028 Bench: readdatavalid latency 10 cycles, num=20 -> never more than 8 reads outstanding; all 20 words in order.
REQ-029 Bench: master_waitrequest randomly high 50% -> outputs stable while stalled; second start write stalls until IDLE.
REQ-030 Bench: num_words=0 -> no master_read/write, done set next cycle; rst_n pulsed mid-copy -> IDLE, status 0, late readdatavalid ignored.
